// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared sizing constants and FSM state type for the bus responder
package mem_bus_responder_pkg;

    localparam int DWIDTH    = 32;
    localparam int CPUAWIDTH = 32;
    localparam int MEM_WORDS = 256;

    // Highest aligned byte address; reserved for the character register.
    localparam logic [CPUAWIDTH-1:0] TX_ADDR = {{(CPUAWIDTH-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2
    } state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - shared tri-state data bus with address/direction/strobe from the initiator
interface mem_bus_responder_if #(
    parameter int DWIDTH    = mem_bus_responder_pkg::DWIDTH,
    parameter int CPUAWIDTH = mem_bus_responder_pkg::CPUAWIDTH
);
    wire  [DWIDTH-1:0]    data;
    logic [CPUAWIDTH-1:0] addr;
    logic                 rw;
    logic                 valid;

    modport master (inout data, output addr, output rw, output valid);
    modport slave  (inout data, input addr, input rw, input valid);

endinterface

// File: rtl/mem_bus_responder_resp_ram.sv
// rtl/mem_bus_responder_resp_ram.sv - word RAM with asynchronous read and synchronous write; never cleared
module resp_ram #(
    parameter int DWIDTH    = 32,
    parameter int MEM_WORDS = 256,
    parameter int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - two-edge memory responder: RAM, memory-mapped tx register and sticky address error
module mem_bus_responder #(
    parameter int DWIDTH    = mem_bus_responder_pkg::DWIDTH,
    parameter int CPUAWIDTH = mem_bus_responder_pkg::CPUAWIDTH,
    parameter int MEM_WORDS = mem_bus_responder_pkg::MEM_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_responder_if.slave  bus,
    output logic [6:0]          tx,
    output logic                tx_stb,
    output logic                busy,
    output logic                err
);
    import mem_bus_responder_pkg::*;

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [CPUAWIDTH-1:0] L_TX_ADDR   = {{(CPUAWIDTH-2){1'b1}}, 2'b00};
    localparam logic [CPUAWIDTH-1:0] L_MEM_WORDS = CPUAWIDTH'(MEM_WORDS);

    state_t               r_state;
    state_t               w_next;
    logic [CPUAWIDTH-1:0] r_addr;
    logic                 r_rw;
    logic [DWIDTH-1:0]    r_wdata;
    logic [6:0]           r_tx;
    logic                 r_tx_stb;
    logic                 r_err;

    logic                 w_live_tx;
    logic                 w_live_inr;
    logic                 w_lat_tx;
    logic                 w_lat_inr;
    logic                 w_commit;
    logic                 w_ram_we;
    logic                 w_drive;
    logic [DWIDTH-1:0]    w_ram_rdata;
    logic [DWIDTH-1:0]    w_rdata;

    assign w_live_tx  = (bus.addr == L_TX_ADDR);
    assign w_live_inr = ((bus.addr >> 2) < L_MEM_WORDS);
    assign w_lat_tx   = (r_addr == L_TX_ADDR);
    assign w_lat_inr  = ((r_addr >> 2) < L_MEM_WORDS);
    assign w_commit   = (r_state == ST_ACC1) && !r_rw;
    assign w_ram_we   = w_commit && w_lat_inr && !w_lat_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.valid) w_next = ST_ACC1;
            ST_ACC1: w_next = ST_ACC2;
            ST_ACC2: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_tx     <= '0;
            r_tx_stb <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tx_stb <= 1'b0;
            if (r_state == ST_IDLE && bus.valid) begin
                r_addr <= bus.addr;
                r_rw   <= bus.rw;
                if (!bus.rw) begin
                    r_wdata <= bus.data;
                end
            end
            // Second edge of the access: flag bad addresses and commit tx writes.
            if (r_state == ST_ACC1) begin
                if (r_addr[1:0] != 2'b00 || (!w_lat_inr && !w_lat_tx)) begin
                    r_err <= 1'b1;
                end
                if (w_commit && w_lat_tx) begin
                    r_tx     <= r_wdata[6:0];
                    r_tx_stb <= 1'b1;
                end
            end
        end
    end

    resp_ram #(
        .DWIDTH    (DWIDTH),
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (AW'(r_addr >> 2)),
        .i_wdata (r_wdata),
        .i_raddr (AW'(bus.addr >> 2)),
        .o_rdata (w_ram_rdata)
    );

    // Read data follows the live address so it is already valid at the first edge.
    always_comb begin
        w_rdata = '0;
        if (w_live_tx) begin
            w_rdata = DWIDTH'(r_tx);
        end else if (w_live_inr) begin
            w_rdata = w_ram_rdata;
        end
    end

    assign w_drive  = bus.valid && bus.rw && reset;
    assign bus.data = w_drive ? w_rdata : 'z;

    assign tx     = r_tx;
    assign tx_stb = r_tx_stb;
    assign busy   = (r_state != ST_IDLE);
    assign err    = r_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - scoreboard bench with reference memory model and randomized accesses
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_responder_if #(.DWIDTH(DWIDTH), .CPUAWIDTH(CPUAWIDTH)) bus ();

    logic [31:0] tb_dout;
    logic        tb_oe;
    assign bus.data = tb_oe ? tb_dout : 'z;

    logic [6:0] tx;
    logic       tx_stb;
    logic       busy;
    logic       err;

    mem_bus_responder #(
        .DWIDTH    (DWIDTH),
        .CPUAWIDTH (CPUAWIDTH),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .tx     (tx),
        .tx_stb (tx_stb),
        .busy   (busy),
        .err    (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [MEM_WORDS];
    logic [6:0]  m_tx  = 7'd0;
    logic        m_err = 1'b0;
    logic [31:0] q_rd [$];
    logic [6:0]  q_tx [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == TX_ADDR) return {25'd0, m_tx};
        if ((a >> 2) < MEM_WORDS) return m_mem[int'(a >> 2)];
        return 32'd0;
    endfunction

    task automatic model_commit(input logic rw, input logic [31:0] a, input logic [31:0] d);
        logic oor;
        oor = ((a >> 2) >= MEM_WORDS) && (a != TX_ADDR);
        if (a[1:0] != 2'b00 || oor) m_err = 1'b1;
        if (!rw) begin
            if (a == TX_ADDR) begin
                m_tx = d[6:0];
                q_tx.push_back(d[6:0]);
            end else if (!oor) begin
                m_mem[int'(a >> 2)] = d;
            end
        end
    endtask

    // Caller is just past a posedge with the responder idle.
    task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic win_rd);
        #1;
        check("busy_idle", 32'(busy), 32'd0);
        bus.valid = 1'b1;
        bus.rw    = rw;
        bus.addr  = a;
        tb_oe     = !rw;
        tb_dout   = d;
        if (rw) q_rd.push_back(model_read(a));
        @(posedge clk);
        #1;
        check("busy_acc1", 32'(busy), 32'd1);
        tb_oe = 1'b0;
        if (win_rd) begin
            bus.rw = 1'b1;
            q_rd.push_back(model_read(a));
        end else begin
            bus.valid = 1'b0;
        end
        @(posedge clk);
        model_commit(rw, a, d);
        #1;
        check("err_p2", 32'(err), 32'(m_err));
        bus.valid = 1'b0;
        bus.rw    = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.valid && bus.rw) begin
                if (q_rd.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no read", bus.data);
                end else begin
                    check("rd_data", bus.data, q_rd.pop_front());
                end
            end
            if (tx_stb) begin
                if (q_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_stb_extra: got pulse tx=%h expected none", tx);
                end else begin
                    check("tx_value", 32'(tx), 32'(q_tx.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        rw;
        int          kind;
        bus.valid = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        tb_oe     = 1'b0;
        tb_dout   = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx", 32'(tx), 32'd0);
        check("rst_tx_stb", 32'(tx_stb), 32'd0);
        reset = 1'b1;
        @(posedge clk);

        for (int i = 0; i < MEM_WORDS; i++) txn(1'b0, 32'(i * 4), $urandom, 1'b0);

        txn(1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 32'h10, 32'd0, 1'b0);
        txn(1'b0, 32'h20, 32'h55, 1'b1);
        txn(1'b1, 32'h20, 32'd0, 1'b0);
        txn(1'b0, TX_ADDR, 32'h41, 1'b0);
        txn(1'b1, TX_ADDR, 32'd0, 1'b0);

        txn(1'b0, 32'h08, 32'h12345678, 1'b0);
        #1;
        bus.valid = 1'b1;
        bus.rw    = 1'b0;
        bus.addr  = 32'h08;
        tb_oe     = 1'b1;
        tb_dout   = 32'h77;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        tb_oe     = 1'b0;
        reset     = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx", 32'(tx), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        m_tx  = 7'd0;
        m_err = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        txn(1'b1, 32'h08, 32'd0, 1'b0);

        txn(1'b1, 32'h13, 32'd0, 1'b0);
        txn(1'b1, 32'h10, 32'd0, 1'b0);
        txn(1'b0, 32'h400, 32'hCAFEF00D, 1'b0);
        txn(1'b1, 32'h400, 32'd0, 1'b0);
        txn(1'b1, 32'h0, 32'd0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 9);
            rw   = 1'($urandom_range(0, 1));
            d    = $urandom;
            if (kind <= 5)      a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            else if (kind == 6) a = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) + 32'($urandom_range(1, 3));
            else if (kind == 7) a = 32'h400 + (32'($urandom_range(0, 1000)) << 2);
            else                a = TX_ADDR;
            txn(rw, a, d, 1'($urandom_range(0, 3) == 0));
        end

        repeat (2) @(posedge clk);
        #1;
        check("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        check("tx_queue_drained", 32'(q_tx.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
